// File: rtl/xor_swap_pkg.sv
// Shared types and default widths for the XOR operand-swap stage.
package xor_swap_pkg;

  localparam int unsigned DefW    = 8;
  localparam int unsigned DefCntW = 16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StX1   = 3'd1,
    StX2   = 3'd2,
    StX3   = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/swap_hold_reg.sv
// One-entry holding register for an (a, b) pair, with a full flag and load/pop controls.
module swap_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] load_a,
  input  logic [W-1:0] load_b,
  output logic         full,
  output logic [W-1:0] a,
  output logic [W-1:0] b
);

  logic         full_q;
  logic [W-1:0] a_q, b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      if (load) begin
        full_q <= 1'b1;
        a_q    <= load_a;
        b_q    <= load_b;
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end
  end

  assign full = full_q;
  assign a    = a_q;
  assign b    = b_q;

endmodule

// File: rtl/xor_swap_unit.sv
// Handshaked operand-swap stage: swaps (a, b) in place with three XOR steps and
// delivers (b, a) downstream, with a one-entry skid for the next pair.
module xor_swap_unit
  import xor_swap_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic             busy,
  output logic [CNT_W-1:0] swap_count
);

  state_e           state_q, state_d;
  logic [W-1:0]     ra_q, ra_d, rb_q, rb_d;
  logic [W-1:0]     out_a_q, out_a_d, out_b_q, out_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hold_full, hold_load, hold_pop;
  logic [W-1:0]     hold_a, hold_b;
  logic             accept, out_fire;

  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;
  assign out_fire = (state_q == StDone) && out_ready;

  // A new pair bypasses the hold register only when the working regs are free this edge.
  assign hold_load = accept && (state_q != StIdle) && !out_fire;

  swap_hold_reg #(
    .W (W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (hold_load),
    .pop    (hold_pop),
    .load_a (in_a),
    .load_b (in_b),
    .full   (hold_full),
    .a      (hold_a),
    .b      (hold_b)
  );

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    cnt_d    = cnt_q;
    hold_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ra_d    = in_a;
          rb_d    = in_b;
          state_d = StX1;
        end
      end
      StX1: begin
        ra_d    = ra_q ^ rb_q;
        state_d = StX2;
      end
      StX2: begin
        rb_d    = rb_q ^ ra_q;
        state_d = StX3;
      end
      StX3: begin
        ra_d    = ra_q ^ rb_q;
        out_a_d = ra_q ^ rb_q;
        out_b_d = rb_q;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (hold_full) begin
            // Held pair is older than anything on the input, so it goes first.
            ra_d     = hold_a;
            rb_d     = hold_b;
            hold_pop = 1'b1;
            state_d  = StX1;
          end else if (accept) begin
            ra_d    = in_a;
            rb_d    = in_b;
            state_d = StX1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = (state_q == StDone);
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign swap_count = cnt_q;
  assign busy       = (state_q != StIdle) || hold_full;

endmodule

// File: tb/tb_xor_swap_unit.sv
// Directed, table-driven bench for xor_swap_unit, plus a CNT_W=4 instance for counter wrap.
module tb_xor_swap_unit;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b, out_a, out_b;
  logic [15:0] swap_count;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [7:0]  w_in_a, w_in_b, w_out_a, w_out_b;
  logic [3:0]  w_swap_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    string      tag;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] pa[3];
  logic [7:0] pb[3];
  bit         saw_low;

  xor_swap_unit #(.W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .busy       (busy),
    .swap_count (swap_count)
  );

  xor_swap_unit #(.W(8), .CNT_W(4)) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (w_in_valid),
    .in_ready   (w_in_ready),
    .in_a       (w_in_a),
    .in_b       (w_in_b),
    .out_valid  (w_out_valid),
    .out_ready  (w_out_ready),
    .out_a      (w_out_a),
    .out_b      (w_out_b),
    .busy       (w_busy),
    .swap_count (w_swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offers one pair with out_ready=1 from idle and checks latency, result and return to idle.
  task automatic run_pair(input vec_t v);
    int n;
    in_a     = v.a;
    in_b     = v.b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({v.tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    // Accept edge moves to X1; X1, X2, X3 each take one edge before DONE.
    check({v.tag, " latency"}, n, 3);
    check({v.tag, " out_a"}, out_a, v.exp_a);
    check({v.tag, " out_b"}, out_b, v.exp_b);
    check({v.tag, " busy_in_done"}, busy, 1);
    @(posedge clk); #1;
    exp_count++;
    check({v.tag, " out_valid_after"}, out_valid, 0);
    check({v.tag, " swap_count"}, swap_count, exp_count);
    check({v.tag, " busy_after"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{a: 8'h3C, b: 8'hA5, exp_a: 8'hA5, exp_b: 8'h3C, tag: "single"};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, exp_a: 8'hFF, exp_b: 8'hFF, tag: "equal"};
    vecs[2] = '{a: 8'h00, b: 8'h7E, exp_a: 8'h7E, exp_b: 8'h00, tag: "zero_a"};
    vecs[3] = '{a: 8'h00, b: 8'h00, exp_a: 8'h00, exp_b: 8'h00, tag: "both_zero"};
    vecs[4] = '{a: 8'h80, b: 8'h01, exp_a: 8'h01, exp_b: 8'h80, tag: "msb_lsb"};
    pa = '{8'h01, 8'h03, 8'h05};
    pb = '{8'h02, 8'h04, 8'h06};

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_out_ready = 1'b1;
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset out_a", out_a, 0);
    check("reset out_b", out_b, 0);
    check("reset swap_count", swap_count, 0);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_pair(vecs[i]);

    // Back-to-back: producer keeps offering, consumer always ready.
    saw_low = 1'b0;
    fork
      begin : producer
        int n;
        for (int i = 0; i < 3; i++) begin
          in_a = pa[i];
          in_b = pb[i];
          in_valid = 1'b1;
          n = 0;
          while (!in_ready && n < 50) begin
            saw_low = 1'b1;
            @(posedge clk); #1; n++;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int n;
        for (int i = 0; i < 3; i++) begin
          n = 0;
          while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
          end
          check($sformatf("b2b[%0d] out_a", i), out_a, pb[i]);
          check($sformatf("b2b[%0d] out_b", i), out_b, pa[i]);
          @(posedge clk); #1;
        end
      end
    join
    exp_count += 3;
    check("b2b in_ready_dropped", saw_low, 1);
    check("b2b swap_count", swap_count, exp_count);
    @(posedge clk); #1;
    check("b2b busy_after", busy, 0);

    // Backpressure: DONE held for 10 cycles, then exactly one transfer.
    begin
      int n;
      bit stable;
      out_ready = 1'b0;
      in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      check("bp out_valid", out_valid, 1);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (!out_valid || out_a !== 8'h34 || out_b !== 8'h12) stable = 1'b0;
      end
      check("bp stable", stable, 1);
      check("bp count_held", swap_count, exp_count);
      out_ready = 1'b1;
      @(posedge clk); #1;
      exp_count++;
      check("bp released", out_valid, 0);
      check("bp count", swap_count, exp_count);
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("bp single_transfer", swap_count, exp_count);
    end

    // Async reset while in X2 with the hold register full.
    begin
      bit seen;
      in_a = 8'h11; in_b = 8'h22; in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = 8'h33; in_b = 8'h44;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("rst pre in_ready", in_ready, 0);
      check("rst pre out_a", out_a, 8'h34);
      #2 rst = 1'b1;
      #1;
      check("rst mid out_valid", out_valid, 0);
      check("rst mid out_a", out_a, 0);
      check("rst mid out_b", out_b, 0);
      check("rst mid busy", busy, 0);
      check("rst mid in_ready", in_ready, 1);
      check("rst mid swap_count", swap_count, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      seen = 1'b0;
      repeat (8) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      check("rst no_stale_output", seen, 0);
      check("rst post swap_count", swap_count, 0);
      check("rst post in_ready", in_ready, 1);
      check("rst post busy", busy, 0);
    end

    // Counter wrap on the 4-bit instance: 17 transfers leave swap_count at 1.
    begin
      int n;
      int k;
      n = 0;
      k = 0;
      w_in_a = 8'h5A; w_in_b = 8'hC3;
      w_in_valid = 1'b1;
      while (k < 17 && n < 500) begin
        @(negedge clk);
        n++;
        if (w_out_valid) k++;
        if (k == 17) w_in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("wrap transfers", k, 17);
      check("wrap swap_count", w_swap_count, 4'd1);
      w_in_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
